// File: rtl/vdu_pkg.sv
// Shared constants, register map and FSM state type for the VDU rectangle-fill blitter.
package vdu_pkg;

  localparam int unsigned FB_W_DEF           = 320;
  localparam int unsigned FB_H_DEF           = 240;
  localparam int unsigned WORDS_PER_LINE_DEF = 80;

  localparam logic [2:0] RegX     = 3'd0;
  localparam logic [2:0] RegY     = 3'd1;
  localparam logic [2:0] RegW     = 3'd2;
  localparam logic [2:0] RegH     = 3'd3;
  localparam logic [2:0] RegColor = 3'd4;
  localparam logic [2:0] RegCtrl  = 3'd5;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlAbort = 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StReq,
    StWait,
    StNext,
    StDone
  } state_e;

endpackage

// File: rtl/vdu_blit_mask.sv
// Byte-lane write mask for one 4-pixel word: lane n is set when pixel 4*word+n lies in
// [x, x_end).
module vdu_blit_mask (
  input  logic [7:0] word_i,
  input  logic [8:0] x_i,
  input  logic [9:0] x_end_i,
  output logic [3:0] mask_o
);

  logic [9:0] pix;

  always_comb begin
    mask_o = '0;
    pix    = '0;
    for (int n = 0; n < 4; n++) begin
      pix       = {word_i, 2'b00} + 10'(n);
      mask_o[n] = (pix >= {1'b0, x_i}) && (pix < x_end_i);
    end
  end

endmodule

// File: rtl/vdu_blitter.sv
// Rectangle-fill blitter: register-programmed clipped fill of an 8 bpp framebuffer,
// issuing one masked 32-bit VRAM write per word over a req/ack master port.
module vdu_blitter
  import vdu_pkg::*;
#(
  parameter int unsigned FB_W           = FB_W_DEF,
  parameter int unsigned FB_H           = FB_H_DEF,
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        sel_i,
  input  logic        wr_en_i,
  input  logic [2:0]  address_in_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        ack_o,
  output logic        vdu_sel_o,
  output logic        vdu_wr_en_o,
  output logic [3:0]  vdu_wr_mask_o,
  output logic [15:0] vdu_address_o,
  output logic [31:0] vdu_data_o,
  input  logic        vdu_ack_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [9:0]  FbW = 10'(FB_W);
  localparam logic [8:0]  FbH = 9'(FB_H);
  localparam logic [15:0] Wpl = 16'(WORDS_PER_LINE);

  state_e      state_q, state_d;
  logic [8:0]  x_q, w_q;
  logic [7:0]  y_q, h_q, color_q;
  logic        done_sticky_q, abort_q, ack_q;
  logic [31:0] data_out_q, rdata;
  logic [9:0]  x_end_q, x_end_d, x_sum, x_end_calc, x_last;
  logic [8:0]  y_end_q, y_end_d, y_sum, y_end_calc;
  logic [8:0]  row_q, row_d;
  logic [15:0] row_base_q, row_base_d, addr;
  logic [7:0]  word_q, word_d, first_word, last_word;
  logic [3:0]  mask;
  logic        busy, active, ctrl_wr, ctrl_rd, start_req, abort_req, abort_now, degenerate;
  logic        unused_bits;

  assign busy    = (state_q != StIdle);
  assign ctrl_wr = sel_i && wr_en_i && (address_in_i == RegCtrl);
  assign ctrl_rd = sel_i && !wr_en_i && (address_in_i == RegCtrl);
  // ABORT wins over START when both are written together while idle.
  assign start_req = ctrl_wr && !busy && data_in_i[CtrlStart] && !data_in_i[CtrlAbort];
  assign abort_req = ctrl_wr && busy && data_in_i[CtrlAbort];
  assign abort_now = abort_q || abort_req;

  assign x_sum      = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum      = {1'b0, y_q} + {1'b0, h_q};
  assign x_end_calc = (x_sum > FbW) ? FbW : x_sum;
  assign y_end_calc = (y_sum > FbH) ? FbH : y_sum;
  assign degenerate = ({1'b0, x_q} >= FbW) || ({1'b0, y_q} >= FbH) ||
                      (w_q == '0) || (h_q == '0);
  assign first_word = {1'b0, x_q[8:2]};
  assign x_last     = x_end_q - 10'd1;
  assign last_word  = x_last[9:2];
  assign addr       = row_base_q + {8'b0, word_q};

  vdu_blit_mask u_mask (
    .word_i  (word_q),
    .x_i     (x_q),
    .x_end_i (x_end_q),
    .mask_o  (mask)
  );

  always_comb begin
    rdata = '0;
    case (address_in_i)
      RegX:     rdata = {23'b0, x_q};
      RegY:     rdata = {24'b0, y_q};
      RegW:     rdata = {23'b0, w_q};
      RegH:     rdata = {24'b0, h_q};
      RegColor: rdata = {24'b0, color_q};
      RegCtrl:  rdata = {30'b0, done_sticky_q, busy};
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    word_d     = word_q;
    case (state_q)
      StIdle: if (start_req) state_d = degenerate ? StDone : StSetup;
      StSetup: begin
        x_end_d    = x_end_calc;
        y_end_d    = y_end_calc;
        row_d      = {1'b0, y_q};
        row_base_d = 16'(y_q) * Wpl;
        word_d     = first_word;
        state_d    = abort_now ? StDone : StReq;
      end
      StReq:  state_d = StWait;
      StWait: if (vdu_ack_i) state_d = abort_now ? StDone : StNext;
      StNext: begin
        if (abort_now) begin
          state_d = StDone;
        end else if (word_q != last_word) begin
          word_d  = word_q + 8'd1;
          state_d = StReq;
        end else if (row_q + 9'd1 == y_end_q) begin
          state_d = StDone;
        end else begin
          row_d      = row_q + 9'd1;
          row_base_d = row_base_q + Wpl;
          word_d     = first_word;
          state_d    = StReq;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      word_q     <= word_d;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      x_q           <= '0;
      y_q           <= '0;
      w_q           <= '0;
      h_q           <= '0;
      color_q       <= '0;
      done_sticky_q <= 1'b0;
      abort_q       <= 1'b0;
      ack_q         <= 1'b0;
      data_out_q    <= '0;
    end else begin
      ack_q      <= sel_i;
      data_out_q <= (sel_i && !wr_en_i) ? rdata : '0;
      if (sel_i && wr_en_i && !busy) begin
        case (address_in_i)
          RegX:     x_q     <= data_in_i[8:0];
          RegY:     y_q     <= data_in_i[7:0];
          RegW:     w_q     <= data_in_i[8:0];
          RegH:     h_q     <= data_in_i[7:0];
          RegColor: color_q <= data_in_i[7:0];
          default:  ;
        endcase
      end
      // A completion in the same cycle as a CTRL read must not be lost.
      if (state_q == StDone) done_sticky_q <= 1'b1;
      else if (ctrl_rd)      done_sticky_q <= 1'b0;
      if (state_q == StDone) abort_q <= 1'b0;
      else if (abort_req)    abort_q <= 1'b1;
    end
  end

  // Address, data and mask stay valid through the whole REQ..ack window.
  assign active        = (state_q == StReq) || (state_q == StWait);
  assign vdu_sel_o     = (state_q == StReq);
  assign vdu_wr_en_o   = (state_q == StReq);
  assign vdu_wr_mask_o = active ? mask : 4'b0;
  assign vdu_address_o = active ? {1'b0, addr[14:0]} : 16'b0;
  assign vdu_data_o    = active ? {4{color_q}} : 32'b0;
  assign busy_o        = busy;
  assign done_o        = (state_q == StDone);
  assign data_out_o    = data_out_q;
  assign ack_o         = ack_q;

  assign unused_bits = ^{data_in_i[31:9], addr[15], x_last[1:0]};

endmodule

// File: doc/vdu_blitter.md
VDU_BLITTER -- requirements
Module: vdu_blitter

Interface
REQ-001 SHALL have parameters FB_W (default 320, pixels per line), FB_H (default 240, lines) and WORDS_PER_LINE (default 80, 32-bit words per line).
REQ-002 SHALL have ports: clk  in  1  system clock; reset_i  in  1  reset.
REQ-003 SHALL have one clock, clk; reset_i is asynchronous and active-high.
REQ-004 SHALL have register slave ports: sel_i in 1; wr_en_i in 1; address_in_i in 3 (register index); data_in_i in 32; data_out_o out 32; ack_o out 1.
REQ-005 SHALL have VDU master ports: vdu_sel_o out 1; vdu_wr_en_o out 1; vdu_wr_mask_o out 4; vdu_address_o out 16 (bit 15 always 0, VRAM space); vdu_data_o out 32; vdu_ack_i in 1.
REQ-006 SHALL have ports busy_o out 1 (fill in progress) and done_o out 1 (one-cycle pulse at fill end).

Function
REQ-007 SHALL map registers: 0 X[8:0], 1 Y[7:0], 2 W[8:0], 3 H[7:0], 4 COLOR[7:0], 5 CTRL (write bit0 START, bit1 ABORT; read bit0 busy, bit1 sticky DONE).
REQ-008 SHALL return ack_o exactly one cycle after any sel_i cycle; reads return zero-extended register values; reading CTRL clears sticky DONE.
REQ-009 SHALL ignore writes to registers 0-4 and START while busy; ABORT is honoured only while busy.
REQ-010 SHALL use pixel layout 8 bpp, 4 pixels per word, pixel n of a word in bits [8n+7:8n], word address = y*WORDS_PER_LINE + (x>>2).
REQ-011 SHALL clip the rectangle to [0,FB_W) x [0,FB_H): x_end = min(X+W, FB_W), y_end = min(Y+H, FB_H), computed at 10/9-bit width without overflow.
REQ-012 SHALL, when X>=FB_W, Y>=FB_H, W==0 or H==0, go IDLE->DONE with no bus request, busy_o high for exactly one cycle.
REQ-013 SHALL use FSM states IDLE, SETUP (latch clipped bounds, row base address), REQ, WAIT, NEXT, DONE.
REQ-014 SHALL make REQ assert vdu_sel_o and vdu_wr_en_o for exactly one cycle; address, data and mask are held stable from REQ until the vdu_ack_i cycle.
REQ-015 SHALL make WAIT wait for vdu_ack_i, with no timeout; the next REQ is no earlier than the cycle after ack.
REQ-016 SHALL drive vdu_data_o as COLOR replicated four times.
REQ-017 SHALL set vdu_wr_mask_o bit n iff pixel 4*word+n lies in [X, x_end); interior words are 4'b1111, and a rectangle inside one word yields both edges in one mask.
REQ-018 SHALL make NEXT step one word right until the last word of the row, then step the row base by WORDS_PER_LINE and return to the first word; after row y_end-1 it goes to DONE.
REQ-019 SHALL make DONE pulse done_o, set sticky DONE, drop busy_o and return to IDLE.
REQ-020 SHALL, on ABORT, finish any outstanding request (WAIT until ack), then enter DONE without further requests.
REQ-021 SHALL give priority to ABORT when START and ABORT are written in the same cycle while idle; START is then ignored.

Reset
REQ-022 SHALL on reset_i set state IDLE, all registers 0, and data_out_o, ack_o, vdu_sel_o, vdu_wr_en_o, vdu_wr_mask_o, vdu_address_o, vdu_data_o, busy_o and done_o to 0.
REQ-023 SHALL, on reset mid-fill, abandon the fill immediately with no further requests; a pending VDU ack after reset is ignored.

Structure
REQ-024 SHALL place FB_W/FB_H/WORDS_PER_LINE defaults, register indices, CTRL bit positions and the FSM state enum in shared package vdu_pkg.
REQ-025 SHALL implement the edge-mask computation as combinational sub-module vdu_blit_mask (inputs word index, X, x_end; output 4-bit mask).

Verification
REQ-026 SHALL cover: X=0,Y=0,W=4,H=1,COLOR=0x5A, START -> one write, addr 0x0000, mask 1111, data 0x5A5A5A5A, then done_o pulse.
REQ-027 SHALL cover: X=1,W=2,Y=0,H=1 -> one write, addr 0, mask 0110.
REQ-028 SHALL cover: X=6,Y=2,W=6,H=2 -> writes addr 161/1100, 162/1111, 241/1100, 242/1111, in that order.
REQ-029 SHALL cover: X=318,W=4,Y=239,H=5 -> single write addr 19199 mask 1100 (clipped in both axes).
REQ-030 SHALL cover: W=0 -> no vdu_sel_o, done_o after 1 busy cycle; START while busy ignored (write count unchanged).
REQ-031 SHALL cover: ABORT during WAIT with ack delayed 3 cycles -> no request after that ack; sticky DONE reads 1 then 0 on re-read; reset_i mid-fill -> all outputs 0 asynchronously.
